seg_wb_ctrl: RTL and testbench
==============================

Name: seg_wb_ctrl

Overview:
Write-side controller for the 8-entry segment register file. It buffers segment-register results from the execute/memory stage in a small in-order queue and drains them one per cycle into the file's single write port (wr_en / wr_reg / wr_data). It also drives a scoreboard so readers of a segment with a pending write stall, and it signals the front end when CS is committed.

Parameters:
DEPTH, 4, queue entries; power of two, 2..8.
DW, 16, segment data width.
AW, 3, segment index width (8 segments).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  producer has a segment write.
in_ready  out  1  queue can accept.
in_seg  in  AW  target segment index.
in_data  in  DW  value to write.
flush  in  1  synchronous discard of all queued, uncommitted writes.
wr_stall  in  1  regfile write port unavailable this cycle.
wr_en  out  1  regfile write enable.
wr_reg  out  AW  regfile write index.
wr_data  out  DW  regfile write data.
cs_commit  out  1  one-cycle pulse after a write to segment 1 (CS) commits.
rd_seg1, rd_seg2, rd_seg3  in  AW  read-port indices being used this cycle.
rd_hazard1, rd_hazard2, rd_hazard3  out  1  reader must stall.
byp_hit1, byp_hit2, byp_hit3  out  1  forwarded value valid (feature only).
byp_data1, byp_data2, byp_data3  out  DW  forwarded value (feature only).
count  out  clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst high at an edge):
  - Pointers and count are cleared to 0 and all entry valid bits are cleared.
  - cs_commit = 0. Consequently wr_en = 0, in_ready = 1, every rd_hazard = 0 and every byp_hit = 0.
  - Reset has priority over every other input, including mid-drain.
- Push: occurs at an edge where in_valid && in_ready && !flush.
  - in_ready = (count < DEPTH), combinational from count only.
  - There is no push-on-pop when full: in_ready stays 0 when full even if a pop happens in the same cycle.
- Drain: wr_en = !empty && !wr_stall && !flush, combinational. wr_reg/wr_data = head entry.
  - The regfile captures the write at the same edge where the head is popped.
- Latency: an entry pushed at edge k into an empty queue drives wr_en during cycle k+1, and the regfile updates at edge k+1. There is no same-cycle input-to-write path.
- Ordering: strictly in order. Duplicate indices are written in push order, so the last write wins.
- Push and pop in the same cycle: count is unchanged.
- Pointers wrap modulo DEPTH.
- cs_commit: a registered pulse, high for exactly the one cycle after an edge where wr_en && wr_reg==1. Back-to-back CS commits give back-to-back pulses.
- flush: at that edge the queue empties (count=0, valid bits cleared).
  - wr_en is forced 0 during the flush cycle.
  - A push presented in the flush cycle is dropped.
  - A cs_commit pulse already registered still fires.
- rd_hazardN = 1 iff any valid queued entry has seg == rd_segN. This is combinational and includes the head entry being written this cycle, which is conservative.
- byp outputs are 0 without the feature.

Optional Feature:
SEG_WB_BYPASS_EN
- Defined:
  - byp_hitN = 1 iff a valid entry matches rd_segN.
  - byp_dataN = data of the youngest matching entry, i.e. the one closest to the tail.
  - rd_hazardN is tied 0.
- Undefined:
  - byp_hitN = 0 and byp_dataN = 0.
  - rd_hazardN is as specified above.

Test Plan:
1. Reset check: rst high 2 cycles then low -> count=0, in_ready=1, wr_en=0, cs_commit=0, all rd_hazard=0.
2. Single write: push seg=3, data=0x1234, wr_stall=0.
   - Next cycle: wr_en=1, wr_reg=3, wr_data=0x1234.
   - Following cycle: count=0, wr_en=0; regfile seg 3 reads 0x1234.
3. Fill the queue: wr_stall=1, push (0,0x0A00), (2,0x2222), (5,0x5555), (2,0x7777).
   - Queue state: count=4, in_ready=0, a 5th push is held.
   - Reader on seg 2: rd_seg1=2 -> rd_hazard1=1 (no bypass); with SEG_WB_BYPASS_EN: byp_hit1=1, byp_data1=0x7777.
   - Drain order: release wr_stall -> writes to 0, 2, 5, 2 on consecutive cycles.
4. CS commit: push seg=1, data=0xF000 -> wr_en with wr_reg=1 in cycle k, cs_commit=1 only in cycle k+1.
5. Flush: wr_stall=1, 3 entries queued; assert flush with in_valid=1 -> next cycle count=0, wr_en=0, no write ever issued for the 4 entries.
6. Reset mid-drain: 3 entries draining; assert rst after the first write -> next cycle count=0, wr_en=0, no further regfile writes.

Source files
------------

// File: rtl/seg_wb_ctrl.sv
// seg_wb_ctrl: in-order write-back queue for the segment register file, with reader scoreboard.
// Define SEG_WB_BYPASS_EN to forward queued data to readers instead of stalling them.
module seg_wb_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 16,
   parameter int unsigned AW    = 3,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_seg,
   input  logic [DW-1:0] in_data,
   input  logic          flush,
   input  logic          wr_stall,
   output logic          wr_en,
   output logic [AW-1:0] wr_reg,
   output logic [DW-1:0] wr_data,
   output logic          cs_commit,
   input  logic [AW-1:0] rd_seg1,
   input  logic [AW-1:0] rd_seg2,
   input  logic [AW-1:0] rd_seg3,
   output logic          rd_hazard1,
   output logic          rd_hazard2,
   output logic          rd_hazard3,
   output logic          byp_hit1,
   output logic          byp_hit2,
   output logic          byp_hit3,
   output logic [DW-1:0] byp_data1,
   output logic [DW-1:0] byp_data2,
   output logic [DW-1:0] byp_data3,
   output logic [CW-1:0] count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [AW-1:0]    seg_q [DEPTH];
   logic [AW-1:0]    seg_d [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DW-1:0]    data_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             cs_commit_q, cs_commit_d;

   logic push, pop, empty;

   assign empty    = (count_q == '0);
   assign in_ready = (count_q < CW'(DEPTH));
   assign push     = in_valid && in_ready && !flush;
   // Reset also gates the write port so nothing reaches the regfile at a reset edge.
   assign wr_en    = !empty && !wr_stall && !flush && !rst;
   assign pop      = wr_en;
   assign wr_reg   = seg_q[head_q];
   assign wr_data  = data_q[head_q];
   assign count    = count_q;
   assign cs_commit = cs_commit_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      seg_d   = seg_q;
      data_d  = data_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         valid_d = '0;
      end else begin
         if (push) begin
            seg_d[tail_q]   = in_seg;
            data_d[tail_q]  = in_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
         end
         if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   assign cs_commit_d = wr_en && (wr_reg == AW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         valid_q     <= '0;
         cs_commit_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         cs_commit_q <= cs_commit_d;
         seg_q       <= seg_d;
         data_q      <= data_d;
      end
   end

   // Scan head to tail so the last match seen is the youngest entry.
   logic [2:0][AW-1:0] rd_seg;
   logic [2:0]         hit;
   logic [2:0][DW-1:0] hit_data;
   logic [PW-1:0]      idx;

   assign rd_seg = {rd_seg3, rd_seg2, rd_seg1};

   always_comb begin
      hit      = '0;
      hit_data = '0;
      idx      = '0;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (seg_q[idx] == rd_seg[r])) begin
               hit[r]      = 1'b1;
               hit_data[r] = data_q[idx];
            end
         end
      end
   end

`ifdef SEG_WB_BYPASS_EN
   assign {rd_hazard3, rd_hazard2, rd_hazard1} = 3'b000;
   assign {byp_hit3, byp_hit2, byp_hit1}       = hit;
   assign byp_data1 = hit_data[0];
   assign byp_data2 = hit_data[1];
   assign byp_data3 = hit_data[2];
`else
   assign {rd_hazard3, rd_hazard2, rd_hazard1} = hit;
   assign {byp_hit3, byp_hit2, byp_hit1}       = 3'b000;
   assign byp_data1 = '0;
   assign byp_data2 = '0;
   assign byp_data3 = '0;
   logic unused_hit_data;
   assign unused_hit_data = ^hit_data;
`endif

endmodule

// File: tb/tb_seg_wb_ctrl.sv
// Directed self-checking bench for seg_wb_ctrl with a small regfile model fed by the write port.
module tb_seg_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_seg;
   logic [15:0] in_data;
   logic        flush;
   logic        wr_stall;
   logic        wr_en;
   logic [2:0]  wr_reg;
   logic [15:0] wr_data;
   logic        cs_commit;
   logic [2:0]  rd_seg1, rd_seg2, rd_seg3;
   logic        rd_hazard1, rd_hazard2, rd_hazard3;
   logic        byp_hit1, byp_hit2, byp_hit3;
   logic [15:0] byp_data1, byp_data2, byp_data3;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   logic [15:0] rf [8];
   int          wr_cnt = 0;

   always #5 clk = ~clk;

   seg_wb_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_seg     (in_seg),
      .in_data    (in_data),
      .flush      (flush),
      .wr_stall   (wr_stall),
      .wr_en      (wr_en),
      .wr_reg     (wr_reg),
      .wr_data    (wr_data),
      .cs_commit  (cs_commit),
      .rd_seg1    (rd_seg1),
      .rd_seg2    (rd_seg2),
      .rd_seg3    (rd_seg3),
      .rd_hazard1 (rd_hazard1),
      .rd_hazard2 (rd_hazard2),
      .rd_hazard3 (rd_hazard3),
      .byp_hit1   (byp_hit1),
      .byp_hit2   (byp_hit2),
      .byp_hit3   (byp_hit3),
      .byp_data1  (byp_data1),
      .byp_data2  (byp_data2),
      .byp_data3  (byp_data3),
      .count      (count)
   );

   always @(posedge clk) begin
      if (wr_en) begin
         rf[wr_reg] <= wr_data;
         wr_cnt     <= wr_cnt + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_seg = '0; in_data = '0; flush = 1'b0; wr_stall = 1'b0;
      rd_seg1 = 3'd0; rd_seg2 = 3'd3; rd_seg3 = 3'd1;
      step(); step();
      rst = 1'b0;
      #1;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
      checks++; if (cs_commit !== 1'b0) begin failures++; $display("FAIL reset_cs_commit got=%b exp=0", cs_commit); end
      checks++; if ({rd_hazard1, rd_hazard2, rd_hazard3} !== 3'b000) begin
         failures++; $display("FAIL reset_hazard got=%b exp=000", {rd_hazard1, rd_hazard2, rd_hazard3}); end
      checks++; if ({byp_hit1, byp_hit2, byp_hit3} !== 3'b000) begin
         failures++; $display("FAIL reset_byp_hit got=%b exp=000", {byp_hit1, byp_hit2, byp_hit3}); end
   endtask

   task automatic test_single_write();
      in_valid = 1'b1; in_seg = 3'd3; in_data = 16'h1234;
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
      checks++; if (wr_reg !== 3'd3) begin failures++; $display("FAIL single_wr_reg got=%0d exp=3", wr_reg); end
      checks++; if (wr_data !== 16'h1234) begin failures++; $display("FAIL single_wr_data got=%h exp=1234", wr_data); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
      step();
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", count); end
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_wr_en_off got=%b exp=0", wr_en); end
      checks++; if (rf[3] !== 16'h1234) begin failures++; $display("FAIL single_rf3 got=%h exp=1234", rf[3]); end
   endtask

   task automatic test_fill_drain();
      logic [2:0]  exp_seg [4];
      logic [15:0] exp_dat [4];
      exp_seg[0] = 3'd0; exp_dat[0] = 16'h0A00;
      exp_seg[1] = 3'd2; exp_dat[1] = 16'h2222;
      exp_seg[2] = 3'd5; exp_dat[2] = 16'h5555;
      exp_seg[3] = 3'd2; exp_dat[3] = 16'h7777;
      wr_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_seg = exp_seg[i]; in_data = exp_dat[i];
         step();
      end
      in_seg = 3'd7; in_data = 16'h9999;
      rd_seg1 = 3'd2; rd_seg2 = 3'd6;
      #1;
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
`ifdef SEG_WB_BYPASS_EN
      checks++; if (byp_hit1 !== 1'b1) begin failures++; $display("FAIL fill_byp_hit1 got=%b exp=1", byp_hit1); end
      checks++; if (byp_data1 !== 16'h7777) begin failures++; $display("FAIL fill_byp_data1 got=%h exp=7777", byp_data1); end
      checks++; if (rd_hazard1 !== 1'b0) begin failures++; $display("FAIL fill_hazard1 got=%b exp=0", rd_hazard1); end
      checks++; if (byp_hit2 !== 1'b0) begin failures++; $display("FAIL fill_byp_hit2 got=%b exp=0", byp_hit2); end
`else
      checks++; if (rd_hazard1 !== 1'b1) begin failures++; $display("FAIL fill_hazard1 got=%b exp=1", rd_hazard1); end
      checks++; if (rd_hazard2 !== 1'b0) begin failures++; $display("FAIL fill_hazard2 got=%b exp=0", rd_hazard2); end
      checks++; if (byp_hit1 !== 1'b0) begin failures++; $display("FAIL fill_byp_hit1 got=%b exp=0", byp_hit1); end
`endif
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_held_count got=%0d exp=4", count); end
      wr_stall = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_in_ready got=%b exp=0", in_ready); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (wr_en !== 1'b1 || wr_reg !== exp_seg[i] || wr_data !== exp_dat[i]) begin
            failures++;
            $display("FAIL drain_%0d got=%b/%0d/%h exp=1/%0d/%h", i, wr_en, wr_reg, wr_data, exp_seg[i], exp_dat[i]);
         end
         step();
      end
      checks++; if (count !== 3'd0 || wr_en !== 1'b0) begin
         failures++; $display("FAIL drain_done got=%0d/%b exp=0/0", count, wr_en); end
      checks++; if (rf[2] !== 16'h7777) begin failures++; $display("FAIL drain_rf2 got=%h exp=7777", rf[2]); end
      checks++; if (rf[7] === 16'h9999) begin failures++; $display("FAIL held_push_written got=%h exp=not 9999", rf[7]); end
      rd_seg1 = 3'd0; rd_seg2 = 3'd3;
   endtask

   task automatic test_cs_commit();
      in_valid = 1'b1; in_seg = 3'd1; in_data = 16'hF000;
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (wr_en !== 1'b1 || wr_reg !== 3'd1) begin
         failures++; $display("FAIL cs_write got=%b/%0d exp=1/1", wr_en, wr_reg); end
      checks++; if (cs_commit !== 1'b0) begin failures++; $display("FAIL cs_early got=%b exp=0", cs_commit); end
      step();
      flush = 1'b1;
      #1;
      checks++; if (cs_commit !== 1'b1) begin failures++; $display("FAIL cs_pulse got=%b exp=1", cs_commit); end
      step();
      flush = 1'b0;
      #1;
      checks++; if (cs_commit !== 1'b0) begin failures++; $display("FAIL cs_pulse_end got=%b exp=0", cs_commit); end
      checks++; if (rf[1] !== 16'hF000) begin failures++; $display("FAIL cs_rf1 got=%h exp=f000", rf[1]); end
      // Two consecutive CS writes.
      in_valid = 1'b1; in_seg = 3'd1; in_data = 16'h00AA;
      step();
      in_data = 16'h00BB;
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (cs_commit !== 1'b1 || wr_en !== 1'b1 || wr_data !== 16'h00BB) begin
         failures++; $display("FAIL cs_b2b_first got=%b/%b/%h exp=1/1/00bb", cs_commit, wr_en, wr_data); end
      step();
      checks++; if (cs_commit !== 1'b1 || wr_en !== 1'b0) begin
         failures++; $display("FAIL cs_b2b_second got=%b/%b exp=1/0", cs_commit, wr_en); end
      step();
      checks++; if (cs_commit !== 1'b0) begin failures++; $display("FAIL cs_b2b_end got=%b exp=0", cs_commit); end
   endtask

   task automatic test_flush();
      int base;
      wr_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_seg = 3'(4 + i); in_data = 16'hC000 + 16'(i);
         step();
      end
      base = wr_cnt;
      flush = 1'b1; wr_stall = 1'b0; in_seg = 3'd7; in_data = 16'hDEAD;
      #1;
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL flush_cycle_wr_en got=%b exp=0", wr_en); end
      step();
      flush = 1'b0; in_valid = 1'b0; rd_seg1 = 3'd4; rd_seg2 = 3'd7;
      #1;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL flush_wr_en got=%b exp=0", wr_en); end
      checks++; if (rd_hazard1 !== 1'b0 || rd_hazard2 !== 1'b0 || byp_hit1 !== 1'b0) begin
         failures++; $display("FAIL flush_scoreboard got=%b%b%b exp=000", rd_hazard1, rd_hazard2, byp_hit1); end
      step(); step();
      checks++; if (wr_cnt !== base) begin failures++; $display("FAIL flush_no_write got=%0d exp=%0d", wr_cnt, base); end
      rd_seg1 = 3'd0; rd_seg2 = 3'd3;
   endtask

   task automatic test_reset_mid_drain();
      int base;
      wr_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_seg = 3'(2 + i); in_data = 16'hB000 + 16'(i);
         step();
      end
      in_valid = 1'b0;
      base = wr_cnt;
      wr_stall = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_wr_en got=%b exp=0", wr_en); end
      step(); step();
      checks++; if (wr_cnt !== base + 1) begin
         failures++; $display("FAIL rstmid_writes got=%0d exp=%0d", wr_cnt - base, 1); end
      checks++; if (rf[2] !== 16'hB000) begin failures++; $display("FAIL rstmid_rf2 got=%h exp=b000", rf[2]); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill_drain();
      test_cs_commit();
      test_flush();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
